// File: rtl/lcd_output_stage_pkg.sv
// Shared types and constants for the LCD output stage; values mirror lcd_defs.vh
// so packaged and include-based users agree on polarity and default widths.
package lcd_output_stage_pkg;

  localparam logic LCD_DE_ACTIVE   = 1'b1;
  localparam logic LCD_SYNC_ACTIVE = 1'b0;

  localparam int DEF_COLOR_BITS = 8;
  localparam int DEF_PWM_BITS   = 8;

  typedef struct packed {
    logic de;
    logic hs_n;
    logic vs_n;
  } sync_t;

  // Idle panel timing: enable inactive, both syncs at their inactive level.
  localparam sync_t SYNC_IDLE = '{de: ~LCD_DE_ACTIVE, hs_n: ~LCD_SYNC_ACTIVE,
                                  vs_n: ~LCD_SYNC_ACTIVE};

endpackage

// File: rtl/LCD_pwm.sv
// Backlight PWM: free-running counter on the pixel tick, duty latched only at the
// period wrap so a brightness change never disturbs the period in progress.
module LCD_pwm
  import lcd_output_stage_pkg::*;
#(
  parameter int PWM_BITS = DEF_PWM_BITS
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                tick,
  input  logic                display_on,
  input  logic [PWM_BITS-1:0] brightness,
  output logic                out
);

  logic [PWM_BITS-1:0] count_q, count_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                out_q, out_d;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    count_d = count_q;
    duty_d  = duty_q;
    out_d   = out_q;
    if (tick) begin
      count_d = count_q + 1'b1;
      if (count_q == '1) duty_d = brightness;
      // Full-scale duty is special-cased so the top count never drops out.
      out_d = display_on && ((duty_q == '1) || (count_q < duty_q));
    end
  end

  // NOTE: sequential state uses non-blocking assignment so all flops update together.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      duty_q  <= '0;
      out_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      duty_q  <= duty_d;
      out_q   <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: rtl/lcd_defs.vh
// Panel polarity constants and default channel widths shared by the LCD control,
// frame-buffer and output-stage blocks.
`ifndef LCD_DEFS_VH
`define LCD_DEFS_VH

`define LCD_DE_ACTIVE          1'b1
`define LCD_SYNC_ACTIVE        1'b0
`define LCD_DEFAULT_COLOR_BITS 8
`define LCD_DEFAULT_PWM_BITS   8

`endif

// File: rtl/lcd_output_stage.sv
// Panel output stage: pixel-clock divider, colour/overlay/blanking register, delayed
// sync path, synchronised display enable and PWM backlight.
module lcd_output_stage
  import lcd_output_stage_pkg::*;
#(
  parameter int CLOCK_DIVIDE = 2,
  parameter int COLOR_BITS   = DEF_COLOR_BITS,
  parameter int PIPE_DELAY   = 1,
  parameter int PWM_BITS     = DEF_PWM_BITS
) (
  input  logic                  clock,
  input  logic                  reset_n,
  output logic                  tick,
  input  logic [COLOR_BITS-1:0] fb_red,
  input  logic [COLOR_BITS-1:0] fb_green,
  input  logic [COLOR_BITS-1:0] fb_blue,
  input  logic                  overlay_bw,
  input  logic                  data_enable_in,
  input  logic                  hs_n_in,
  input  logic                  vs_n_in,
  input  logic                  display_on,
  input  logic [PWM_BITS-1:0]   brightness,
  output logic                  lcd_clock,
  output logic                  lcd_data_enable,
  output logic                  lcd_hs_n,
  output logic                  lcd_vs_n,
  output logic                  lcd_display_on,
  output logic                  lcd_backlight,
  output logic [COLOR_BITS-1:0] lcd_red,
  output logic [COLOR_BITS-1:0] lcd_green,
  output logic [COLOR_BITS-1:0] lcd_blue
);

  localparam int            CW       = $clog2(CLOCK_DIVIDE);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLOCK_DIVIDE - 1);
  localparam logic [CW-1:0] DIV_HALF = CW'(CLOCK_DIVIDE / 2);

  logic [CW-1:0]         div_q, div_d;
  logic                  lcd_clock_q, lcd_clock_d;
  logic                  disp_meta_q, disp_sync_q;
  sync_t                 sync_in, sync_dly;
  sync_t                 sync_out_q, sync_out_d;
  logic                  disp_out_q, disp_out_d;
  logic [COLOR_BITS-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;

  assign tick    = (div_q == DIV_LAST);
  assign sync_in = '{de: data_enable_in, hs_n: hs_n_in, vs_n: vs_n_in};

  generate
    if (PIPE_DELAY == 0) begin : g_no_pipe
      assign sync_dly = sync_in;
    end else begin : g_pipe
      sync_t pipe_q [PIPE_DELAY];
      sync_t pipe_d [PIPE_DELAY];

      always_comb begin
        pipe_d = pipe_q;
        if (tick) begin
          pipe_d[0] = sync_in;
          for (int i = 1; i < PIPE_DELAY; i++) pipe_d[i] = pipe_q[i-1];
        end
      end

      // NOTE: the delay line is a handful of flops, not a RAM, so every stage is reset.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < PIPE_DELAY; i++) pipe_q[i] <= SYNC_IDLE;
        end else begin
          pipe_q <= pipe_d;
        end
      end

      assign sync_dly = pipe_q[PIPE_DELAY-1];
    end
  endgenerate

  always_comb begin
    div_d       = tick ? '0 : div_q + 1'b1;
    // Registered from the next count so lcd_clock tracks the counter without lag.
    lcd_clock_d = (div_d >= DIV_HALF);
    sync_out_d  = sync_out_q;
    disp_out_d  = disp_out_q;
    red_d       = red_q;
    green_d     = green_q;
    blue_d      = blue_q;
    if (tick) begin
      sync_out_d    = sync_dly;
      sync_out_d.de = sync_dly.de && disp_sync_q;
      disp_out_d    = disp_sync_q;
      if (!disp_sync_q) begin
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
      end else if (overlay_bw) begin
        red_d   = '1;
        green_d = '1;
        blue_d  = '1;
      end else begin
        red_d   = fb_red;
        green_d = fb_green;
        blue_d  = fb_blue;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_q       <= '0;
      lcd_clock_q <= 1'b0;
      disp_meta_q <= 1'b0;
      disp_sync_q <= 1'b0;
      sync_out_q  <= SYNC_IDLE;
      disp_out_q  <= 1'b0;
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
    end else begin
      div_q       <= div_d;
      lcd_clock_q <= lcd_clock_d;
      disp_meta_q <= display_on;
      disp_sync_q <= disp_meta_q;
      sync_out_q  <= sync_out_d;
      disp_out_q  <= disp_out_d;
      red_q       <= red_d;
      green_q     <= green_d;
      blue_q      <= blue_d;
    end
  end

  LCD_pwm #(.PWM_BITS(PWM_BITS)) u_pwm (
    .clock      (clock),
    .reset_n    (reset_n),
    .tick       (tick),
    .display_on (disp_sync_q),
    .brightness (brightness),
    .out        (lcd_backlight)
  );

  assign lcd_clock       = lcd_clock_q;
  assign lcd_data_enable = sync_out_q.de;
  assign lcd_hs_n        = sync_out_q.hs_n;
  assign lcd_vs_n        = sync_out_q.vs_n;
  assign lcd_display_on  = disp_out_q;
  assign lcd_red         = red_q;
  assign lcd_green       = green_q;
  assign lcd_blue        = blue_q;

endmodule

// File: tb/tb_lcd_output_stage.sv
// Scoreboard bench for lcd_output_stage: expected panel values are queued when
// stimulus is applied on a tick and compared when the panel registers present them.
module tb_lcd_output_stage;

  localparam int CD = 4;
  localparam int PD = 2;
  localparam int CB = 8;
  localparam int PB = 8;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          tick;
  logic [CB-1:0] fb_red = '0, fb_green = '0, fb_blue = '0;
  logic          overlay_bw = 1'b0;
  logic          data_enable_in = 1'b0, hs_n_in = 1'b1, vs_n_in = 1'b1;
  logic          display_on = 1'b0;
  logic [PB-1:0] brightness = '0;
  logic          lcd_clock, lcd_data_enable, lcd_hs_n, lcd_vs_n;
  logic          lcd_display_on, lcd_backlight;
  logic [CB-1:0] lcd_red, lcd_green, lcd_blue;

  always #5 clock = ~clock;

  lcd_output_stage #(
    .CLOCK_DIVIDE (CD),
    .COLOR_BITS   (CB),
    .PIPE_DELAY   (PD),
    .PWM_BITS     (PB)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .tick            (tick),
    .fb_red          (fb_red),
    .fb_green        (fb_green),
    .fb_blue         (fb_blue),
    .overlay_bw      (overlay_bw),
    .data_enable_in  (data_enable_in),
    .hs_n_in         (hs_n_in),
    .vs_n_in         (vs_n_in),
    .display_on      (display_on),
    .brightness      (brightness),
    .lcd_clock       (lcd_clock),
    .lcd_data_enable (lcd_data_enable),
    .lcd_hs_n        (lcd_hs_n),
    .lcd_vs_n        (lcd_vs_n),
    .lcd_display_on  (lcd_display_on),
    .lcd_backlight   (lcd_backlight),
    .lcd_red         (lcd_red),
    .lcd_green       (lcd_green),
    .lcd_blue        (lcd_blue)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Independent divider phase, counted from reset release.
  int phase = 0;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) phase <= 0;
    else          phase <= (phase + 1) % CD;
  end

  always @(negedge clock) begin
    check("tick", tick, (phase == CD - 1));
    check("lcd_clock", lcd_clock, (phase >= CD / 2));
  end

  typedef struct packed {logic [CB-1:0] r, g, b;} col_t;
  typedef struct packed {logic de, hs, vs;} syn_t;

  col_t          col_q[$];
  syn_t          syn_q[$];
  logic          disp_p1, disp_p2;
  logic [PB-1:0] bright_p1, m_cnt, m_duty;
  bit            first;
  int            hi_cnt;
  int            hs_toggles;
  logic          last_hs;

  task automatic model_reset();
    col_q.delete();
    syn_q.delete();
    col_q.push_back('0);
    repeat (PD + 1) syn_q.push_back(syn_t'{de: 1'b0, hs: 1'b1, vs: 1'b1});
    disp_p1 = 1'b0;
    disp_p2 = 1'b0;
    bright_p1 = '0;
    m_cnt = '0;
    m_duty = '0;
    first = 1'b1;
    last_hs = 1'b1;
  endtask

  // Wait for the next tick, check what the panel shows, then apply this tick's inputs.
  task automatic step(input logic de, input logic hs, input logic vs,
                      input logic [CB-1:0] r, input logic [CB-1:0] g, input logic [CB-1:0] b,
                      input logic ov, input logic dsp, input logic [PB-1:0] br);
    int   w;
    col_t ec;
    syn_t es;
    logic exp_bl;
    w = 0;
    @(negedge clock);
    while (tick !== 1'b1 && w < 4 * CD) begin
      @(negedge clock);
      w++;
    end
    if (tick !== 1'b1) begin
      check("tick_timeout", 32'd0, 32'd1);
      return;
    end
    ec = col_q.pop_front();
    check("red", lcd_red, ec.r);
    check("green", lcd_green, ec.g);
    check("blue", lcd_blue, ec.b);
    es = syn_q.pop_front();
    check("data_enable", lcd_data_enable, es.de & disp_p2);
    check("hs_n", lcd_hs_n, es.hs);
    check("vs_n", lcd_vs_n, es.vs);
    check("display_on", lcd_display_on, disp_p2);
    exp_bl = disp_p2 && ((m_duty == 8'hFF) || (m_cnt < m_duty));
    check("backlight", lcd_backlight, exp_bl);
    hi_cnt += int'(lcd_backlight);
    if (lcd_hs_n !== last_hs) hs_toggles++;
    last_hs = lcd_hs_n;
    if (!first) begin
      if (m_cnt == 8'hFF) m_duty = bright_p1;
      m_cnt++;
    end
    first = 1'b0;
    col_q.push_back(!disp_p1 ? col_t'('0) : (ov ? col_t'('1) : col_t'{r: r, g: g, b: b}));
    syn_q.push_back(syn_t'{de: de, hs: hs, vs: vs});
    disp_p2 = disp_p1;
    disp_p1 = dsp;
    bright_p1 = br;
    data_enable_in = de;
    hs_n_in = hs;
    vs_n_in = vs;
    fb_red = r;
    fb_green = g;
    fb_blue = b;
    overlay_bw = ov;
    display_on = dsp;
    brightness = br;
  endtask

  task automatic rnd_step(input logic ov, input logic dsp, input logic [PB-1:0] br);
    logic [2:0] s;
    s = 3'($urandom_range(0, 7));
    step(s[0], s[1], s[2], 8'($urandom), 8'($urandom), 8'($urandom), ov, dsp, br);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clock);
    #2 reset_n = 1'b1;

    repeat (12) rnd_step(1'b0, 1'b1, 8'd64);

    // Overlay forces white, then the frame buffer shows through.
    step(1'b1, 1'b0, 1'b1, 8'h12, 8'h34, 8'h56, 1'b1, 1'b1, 8'd64);
    step(1'b1, 1'b1, 1'b1, 8'h12, 8'h34, 8'h56, 1'b0, 1'b1, 8'd64);
    // Single-tick enable pulse with a marker colour.
    step(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'd64);
    step(1'b1, 1'b1, 1'b1, 8'h5A, 8'h00, 8'h00, 1'b0, 1'b1, 8'd64);
    repeat (4) step(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'd64);

    // Backlight duty over steady full periods.
    repeat (260) rnd_step(1'b0, 1'b1, 8'd0);
    hi_cnt = 0;
    repeat (256) rnd_step(1'b0, 1'b1, 8'd0);
    check("bl_high_duty0", hi_cnt, 0);
    repeat (260) rnd_step(1'b0, 1'b1, 8'd255);
    hi_cnt = 0;
    repeat (256) rnd_step(1'b0, 1'b1, 8'd255);
    check("bl_high_duty255", hi_cnt, 256);
    repeat (260) rnd_step(1'b0, 1'b1, 8'd64);
    hi_cnt = 0;
    repeat (256) rnd_step(1'b0, 1'b1, 8'd64);
    check("bl_high_duty64", hi_cnt, 64);
    repeat (100) rnd_step(1'b0, 1'b0 == 1'b1 ? 1'b0 : 1'b1, 8'd64);
    repeat (300) rnd_step(1'b0, 1'b1, 8'd128);

    // Blanking: syncs must keep running while everything else is held low.
    hs_toggles = 0;
    for (int i = 0; i < 24; i++)
      step(1'b1, 1'(i % 2), 1'(i / 4 % 2), 8'hAA, 8'hBB, 8'hCC, 1'(i % 3 == 0), 1'b0, 8'd255);
    check("hs_toggles_blank", (hs_toggles > 10), 1'b1);
    repeat (8) rnd_step(1'b1, 1'b1, 8'd255);
    step(1'b1, 1'b0, 1'b0, 8'h11, 8'h22, 8'h33, 1'b1, 1'b1, 8'd255);
    repeat (3) step(1'b1, 1'b0, 1'b0, 8'h11, 8'h22, 8'h33, 1'b1, 1'b1, 8'd255);

    // Mid-line asynchronous reset, checked between clock edges.
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("rst_red", lcd_red, 8'h00);
    check("rst_green", lcd_green, 8'h00);
    check("rst_blue", lcd_blue, 8'h00);
    check("rst_de", lcd_data_enable, 1'b0);
    check("rst_hs_n", lcd_hs_n, 1'b1);
    check("rst_vs_n", lcd_vs_n, 1'b1);
    check("rst_display_on", lcd_display_on, 1'b0);
    check("rst_backlight", lcd_backlight, 1'b0);
    check("rst_tick", tick, 1'b0);
    check("rst_lcd_clock", lcd_clock, 1'b0);
    display_on = 1'b0;
    overlay_bw = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    #2 reset_n = 1'b1;
    repeat (30) rnd_step(1'($urandom_range(0, 1)), 1'b1, 8'd200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
